// File: rtl/lut_dump_pkg.sv
// Shared types and default sizes for the LUT dump capture controller.
package lut_dump_pkg;

    localparam int unsigned LUT_AW = 12;
    localparam int unsigned LUT_DW = 8;
    localparam int unsigned LUT_CW = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } state_t;

endpackage : lut_dump_pkg

// File: rtl/lut_dump_decim.sv
// Decimation counter: keeps one of every (decim+1) valid samples.
// The counter restarts on i_clr (the trigger cycle), so the trigger-cycle sample is kept.
module lut_dump_decim
    import lut_dump_pkg::*;
#(
    parameter int unsigned CW = LUT_CW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_clr,
    input  logic          i_en,
    input  logic          i_in_valid,
    input  logic [CW-1:0] i_decim,
    output logic          o_accept_c
);

    logic [CW-1:0] r_cnt;

    // A sample is kept when the phase counter sits at zero (forced zero on clear).
    assign o_accept_c = i_in_valid & (i_clr | (r_cnt == '0));

    // Phase counter advances once per valid sample and wraps at decim.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            if (i_in_valid && (i_decim != '0)) begin
                r_cnt <= CW'(1);
            end else begin
                r_cnt <= '0;
            end
        end else if (i_en && i_in_valid) begin
            if (r_cnt == i_decim) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

endmodule : lut_dump_decim

// File: rtl/lut_dump_capture_ctrl.sv
// Fabric-side writer for the LUT dump buffer: arm, trigger, stream samples into port A.
// Optional decimation is compiled in with `define LUT_DUMP_DECIM_EN.
module lut_dump_capture_ctrl
    import lut_dump_pkg::*;
#(
    parameter int unsigned AW = LUT_AW,
    parameter int unsigned DW = LUT_DW,
    parameter int unsigned CW = LUT_CW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          arm,
    input  logic          abort,
    input  logic [AW-1:0] len_m1,
    input  logic [CW-1:0] decim,
    input  logic          trigger,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    output logic          bram_we,
    output logic          bram_en_a,
    output logic [AW-1:0] bram_addr,
    output logic [DW-1:0] bram_wr_data,
    output logic          busy,
    output logic          done,
    output logic [AW:0]   wr_count
);

    state_t        r_state;
    state_t        w_state_nxt;
    logic          w_load;
    logic          r_arm_q;
    logic          w_arm_edge;
    logic          w_trig;
    logic          w_cap;
    logic          w_accept;
    logic          w_write;
    logic          w_last;
    logic [AW-1:0] r_len_m1;
    logic [AW-1:0] r_addr;
    logic [AW:0]   r_wr_count;
    logic          r_bram_we;
    logic [AW-1:0] r_bram_addr;
    logic [DW-1:0] r_bram_wr_data;
    logic          r_busy;
    logic          r_done;

    // Delayed copy of the software arm bit for rising-edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_arm_q <= 1'b0;
        end else begin
            r_arm_q <= arm;
        end
    end

    assign w_arm_edge = arm & ~r_arm_q;
    assign w_trig     = (r_state == ARMED) & trigger & ~abort;
    assign w_cap      = (r_state == CAPTURE) & ~abort;

`ifdef LUT_DUMP_DECIM_EN
    logic [CW-1:0] r_decim;

    // Decimation ratio is frozen for the whole capture at arm time.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_decim <= '0;
        end else if (w_load) begin
            r_decim <= decim;
        end
    end

    lut_dump_decim #(
        .CW(CW)
    ) u_decim (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_clr     (w_trig),
        .i_en      (w_cap),
        .i_in_valid(in_valid),
        .i_decim   (r_decim),
        .o_accept_c(w_accept)
    );
`else
    logic w_unused_decim;
    assign w_unused_decim = ^decim;
    assign w_accept       = in_valid;
`endif

    assign w_write = (w_trig | w_cap) & w_accept;
    assign w_last  = w_write & (r_addr == r_len_m1);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; abort wins over everything, arm edges only act from IDLE/DONE.
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        if (abort) begin
            w_state_nxt = IDLE;
        end else begin
            unique case (r_state)
                IDLE, DONE: begin
                    if (w_arm_edge) begin
                        w_state_nxt = ARMED;
                        w_load      = 1'b1;
                    end
                end
                ARMED: begin
                    if (trigger) begin
                        w_state_nxt = w_last ? DONE : CAPTURE;
                    end
                end
                CAPTURE: begin
                    if (w_last) begin
                        w_state_nxt = DONE;
                    end
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    // Capture bookkeeping: length, write pointer (never wraps) and sample count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_len_m1   <= '0;
            r_addr     <= '0;
            r_wr_count <= '0;
        end else if (w_load) begin
            r_len_m1   <= len_m1;
            r_addr     <= '0;
            r_wr_count <= '0;
        end else if (w_write) begin
            r_wr_count <= r_wr_count + (AW+1)'(1);
            if (!w_last) begin
                r_addr <= r_addr + AW'(1);
            end
        end
    end

    // Registered port-A write and status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bram_we      <= 1'b0;
            r_bram_addr    <= '0;
            r_bram_wr_data <= '0;
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
        end else begin
            r_bram_we <= w_write;
            if (w_write) begin
                r_bram_addr    <= r_addr;
                r_bram_wr_data <= in_data;
            end
            r_busy <= (w_state_nxt == ARMED) || (w_state_nxt == CAPTURE);
            r_done <= (r_state == DONE) && (w_state_nxt == DONE);
        end
    end

    assign bram_we      = r_bram_we;
    assign bram_en_a    = r_bram_we;
    assign bram_addr    = r_bram_addr;
    assign bram_wr_data = r_bram_wr_data;
    assign busy         = r_busy;
    assign done         = r_done;
    assign wr_count     = r_wr_count;

endmodule : lut_dump_capture_ctrl

// File: tb/tb_lut_dump_capture_ctrl.sv
// Self-checking bench for lut_dump_capture_ctrl: directed vector table, corner-case
// sequences and randomized traffic against a transaction-level capture model.
module tb_lut_dump_capture_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        arm, abort, trigger, in_valid;
    logic [11:0] len_m1;
    logic [7:0]  decim;
    logic [7:0]  in_data;
    logic        bram_we, bram_en_a, busy, done;
    logic [11:0] bram_addr;
    logic [7:0]  bram_wr_data;
    logic [12:0] wr_count;

    int n_checks = 0;
    int n_fail   = 0;
    int n_writes = 0;
    int last_addr = 0;
    int wq_data[$];

    lut_dump_capture_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .arm         (arm),
        .abort       (abort),
        .len_m1      (len_m1),
        .decim       (decim),
        .trigger     (trigger),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .bram_we     (bram_we),
        .bram_en_a   (bram_en_a),
        .bram_addr   (bram_addr),
        .bram_wr_data(bram_wr_data),
        .busy        (busy),
        .done        (done),
        .wr_count    (wr_count)
    );

    always #5 clk = ~clk;

    // Reference model: phase 0=idle 1=armed 2=capturing 3=complete.
    int m_phase, m_len, m_decim, m_ptr, m_cnt, m_count;
    bit m_arm_prev;
    bit e_we, e_done, e_busy;
    int e_addr, e_data;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h expected=%0h @%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase = 0; m_len = 0; m_decim = 0; m_ptr = 0; m_cnt = 0; m_count = 0;
        m_arm_prev = 1'b0; e_we = 1'b0; e_done = 1'b0; e_busy = 1'b0; e_addr = 0; e_data = 0;
    endtask

    task automatic take_sample();
        bit keep;
        keep = in_valid;
`ifdef LUT_DUMP_DECIM_EN
        if (in_valid) begin
            keep  = (m_cnt == 0);
            m_cnt = (m_cnt == m_decim) ? 0 : m_cnt + 1;
        end
`endif
        if (keep) begin
            e_we   = 1'b1;
            e_addr = m_ptr;
            e_data = int'(in_data);
            m_count++;
            if (m_ptr == m_len) m_phase = 3;
            else                m_ptr++;
        end
    endtask

    task automatic model_step();
        bit rise;
        int prev;
        rise       = arm && !m_arm_prev;
        m_arm_prev = arm;
        prev       = m_phase;
        e_we       = 1'b0;
        if (abort) begin
            m_phase = 0;
        end else if ((m_phase == 0 || m_phase == 3) && rise) begin
            m_phase = 1; m_len = int'(len_m1); m_decim = int'(decim); m_ptr = 0; m_count = 0;
        end else if (m_phase == 1 && trigger) begin
            m_phase = 2; m_cnt = 0;
            take_sample();
        end else if (m_phase == 2) begin
            take_sample();
        end
        e_done = (prev == 3) && (m_phase == 3);
        e_busy = (m_phase == 1) || (m_phase == 2);
    endtask

    // One clock: inputs already driven; sample 1 time unit after the edge and compare to model.
    task automatic tick();
        @(posedge clk);
        #1;
        model_step();
        chk("we", 32'(bram_we), 32'(e_we));
        chk("en_a", 32'(bram_en_a), 32'(e_we));
        chk("done", 32'(done), 32'(e_done));
        chk("busy", 32'(busy), 32'(e_busy));
        chk("wr_count", 32'(wr_count), 32'(m_count));
        if (e_we) begin
            chk("addr", 32'(bram_addr), 32'(e_addr));
            chk("wdata", 32'(bram_wr_data), 32'(e_data));
        end
        if (bram_we) begin
            n_writes++;
            last_addr = int'(bram_addr);
            wq_data.push_back(int'(bram_wr_data));
        end
    endtask

    task automatic drive(input bit a, input bit ab, input bit t, input bit v, input logic [7:0] d);
        arm = a; abort = ab; trigger = t; in_valid = v; in_data = d;
    endtask

    typedef struct {
        bit          arm, abort, trig, valid;
        logic [7:0]  data;
        bit          we;
        logic [11:0] addr;
        logic [7:0]  wdata;
        bit          done, busy;
        logic [12:0] cnt;
    } vec_t;

    function automatic vec_t mk(bit a, bit ab, bit t, bit v, logic [7:0] d,
                                bit we, int ad, logic [7:0] wd, bit dn, bit bs, int c);
        vec_t r;
        r.arm = a; r.abort = ab; r.trig = t; r.valid = v; r.data = d;
        r.we = we; r.addr = 12'(ad); r.wdata = wd; r.done = dn; r.busy = bs; r.cnt = 13'(c);
        return r;
    endfunction

    vec_t tbl[21];

    initial begin
        // Basic len_m1=7 capture followed by arm/trigger/abort collisions.
        tbl[0] = mk(1, 0, 0, 0, 8'h00, 0, 0, 8'h00, 0, 1, 0);
        tbl[1] = mk(1, 0, 1, 1, 8'h10, 1, 0, 8'h10, 0, 1, 1);
        for (int k = 2; k <= 7; k++)
            tbl[k] = mk(1, 0, 0, 1, 8'(8'h0F + k), 1, k - 1, 8'(8'h0F + k), 0, 1, k);
        tbl[8]  = mk(1, 0, 0, 1, 8'h17, 1, 7, 8'h17, 0, 0, 8);
        tbl[9]  = mk(1, 0, 0, 1, 8'h99, 0, 0, 8'h00, 1, 0, 8);
        tbl[10] = mk(0, 0, 0, 1, 8'h98, 0, 0, 8'h00, 1, 0, 8);
        tbl[11] = mk(1, 0, 1, 1, 8'h55, 0, 0, 8'h00, 0, 1, 0);
        tbl[12] = mk(0, 0, 0, 1, 8'h56, 0, 0, 8'h00, 0, 1, 0);
        tbl[13] = mk(0, 0, 1, 1, 8'h20, 1, 0, 8'h20, 0, 1, 1);
        tbl[14] = mk(1, 0, 0, 1, 8'h21, 1, 1, 8'h21, 0, 1, 2);
        tbl[15] = mk(0, 0, 0, 0, 8'h00, 0, 0, 8'h00, 0, 1, 2);
        tbl[16] = mk(1, 1, 0, 1, 8'h22, 0, 0, 8'h00, 0, 0, 2);
        tbl[17] = mk(1, 0, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 2);
        tbl[18] = mk(0, 0, 1, 1, 8'h23, 0, 0, 8'h00, 0, 0, 2);
        tbl[19] = mk(1, 0, 0, 0, 8'h00, 0, 0, 8'h00, 0, 1, 0);
        tbl[20] = mk(0, 1, 1, 1, 8'h24, 0, 0, 8'h00, 0, 0, 0);

        rst_n = 1'b0;
        drive(0, 0, 0, 0, 8'h00);
        len_m1 = 12'd7;
        decim  = 8'd0;
        model_reset();
        #12;
        chk("rst_we", 32'(bram_we), 32'd0);
        chk("rst_en_a", 32'(bram_en_a), 32'd0);
        chk("rst_addr", 32'(bram_addr), 32'd0);
        chk("rst_wdata", 32'(bram_wr_data), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_count", 32'(wr_count), 32'd0);
        #1 rst_n = 1'b1;

        // Idle with toggling samples and no arm: nothing may be written.
        for (int i = 0; i < 10; i++) begin
            drive(0, 0, i[1], i[0], 8'(i));
            tick();
        end
        chk("idle_no_write", 32'(n_writes), 32'd0);

        // Directed vector table.
        for (int i = 0; i < 21; i++) begin
            drive(tbl[i].arm, tbl[i].abort, tbl[i].trig, tbl[i].valid, tbl[i].data);
            tick();
            chk($sformatf("tbl%0d_we", i), 32'(bram_we), 32'(tbl[i].we));
            chk($sformatf("tbl%0d_done", i), 32'(done), 32'(tbl[i].done));
            chk($sformatf("tbl%0d_busy", i), 32'(busy), 32'(tbl[i].busy));
            chk($sformatf("tbl%0d_cnt", i), 32'(wr_count), 32'(tbl[i].cnt));
            if (tbl[i].we) begin
                chk($sformatf("tbl%0d_addr", i), 32'(bram_addr), 32'(tbl[i].addr));
                chk($sformatf("tbl%0d_data", i), 32'(bram_wr_data), 32'(tbl[i].wdata));
            end
        end

        // Abort after five writes of a 16-sample capture, then re-arm from address 0.
        len_m1 = 12'd15;
        drive(0, 0, 0, 0, 8'h00); tick();
        drive(1, 0, 0, 0, 8'h00); tick();
        for (int i = 0; i < 5; i++) begin
            drive(1, 0, i == 0, 1, 8'(8'h40 + i));
            tick();
        end
        drive(1, 1, 0, 1, 8'h50); tick();
        chk("abort_we", 32'(bram_we), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_count", 32'(wr_count), 32'd5);
        drive(0, 0, 0, 0, 8'h00); tick();
        drive(1, 0, 0, 0, 8'h00); tick();
        drive(1, 0, 1, 1, 8'hA5); tick();
        chk("rearm_we", 32'(bram_we), 32'd1);
        chk("rearm_addr", 32'(bram_addr), 32'd0);
        chk("rearm_data", 32'(bram_wr_data), 32'hA5);
        drive(0, 1, 0, 0, 8'h00); tick();

        // Full buffer with sparse samples: 4096 writes, no wrap, nothing past the end.
        len_m1 = 12'd4095;
        drive(0, 0, 0, 0, 8'h00); tick();
        drive(1, 0, 0, 0, 8'h00); tick();
        n_writes = 0;
        for (int i = 0; i < 13000 && !done; i++) begin
            drive(1, 0, i == 0, (i % 3) == 0, 8'(i));
            tick();
        end
        chk("full_done", 32'(done), 32'd1);
        chk("full_writes", 32'(n_writes), 32'd4096);
        chk("full_last_addr", 32'(last_addr), 32'd4095);
        chk("full_count", 32'(wr_count), 32'd4096);
        for (int i = 0; i < 9; i++) begin
            drive(1, 0, 1, 1, 8'hEE);
            tick();
        end
        chk("full_no_extra", 32'(n_writes), 32'd4096);
        drive(0, 1, 0, 0, 8'h00); tick();

        // Asynchronous reset in the middle of a capture.
        len_m1 = 12'd15;
        drive(0, 0, 0, 0, 8'h00); tick();
        drive(1, 0, 0, 0, 8'h00); tick();
        for (int i = 0; i < 3; i++) begin
            drive(1, 0, i == 0, 1, 8'(8'h60 + i));
            tick();
        end
        rst_n = 1'b0;
        #2;
        chk("mrst_we", 32'(bram_we), 32'd0);
        chk("mrst_busy", 32'(busy), 32'd0);
        chk("mrst_count", 32'(wr_count), 32'd0);
        chk("mrst_addr", 32'(bram_addr), 32'd0);
        drive(0, 0, 0, 0, 8'h00);
        model_reset();
        #1 rst_n = 1'b1;
        tick();

`ifdef LUT_DUMP_DECIM_EN
        // Decimate by 4 over a 0..15 ramp: data 0,4,8,12 land at addresses 0..3.
        len_m1 = 12'd3;
        decim  = 8'd3;
        drive(1, 0, 0, 0, 8'h00); tick();
        wq_data.delete();
        for (int i = 0; i < 16; i++) begin
            drive(1, 0, i == 0, 1, 8'(i));
            tick();
        end
        chk("decim_writes", 32'(wq_data.size()), 32'd4);
        for (int i = 0; i < 4 && i < wq_data.size(); i++)
            chk($sformatf("decim_data%0d", i), 32'(wq_data[i]), 32'(4 * i));
        chk("decim_done", 32'(done), 32'd1);
        chk("decim_count", 32'(wr_count), 32'd4);
        drive(0, 1, 0, 0, 8'h00); tick();
`endif

        // Randomized traffic against the model.
        drive(0, 0, 0, 0, 8'h00);
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 19) == 0) arm = ~arm;
            abort    = ($urandom_range(0, 59) == 0);
            trigger  = ($urandom_range(0, 5) == 0);
            in_valid = $urandom_range(0, 1) == 1;
            in_data  = 8'($urandom);
            len_m1   = 12'($urandom_range(0, 15));
            decim    = 8'($urandom_range(0, 3));
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule : tb_lut_dump_capture_ctrl
